// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_scheduler
// Purpose  : Round-robin sharing of one combinational 8-bit ALU between two
//            requesters, with per-requester accumulators and a held response.
// Revision : 1.0
// ============================================================================
module alu_op_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req0_use_acc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [2:0]       req1_sel,
    input  logic             req1_use_acc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic [7:0]       r_acc0;
    logic [7:0]       r_acc1;
    logic [7:0]       r_op_a;
    logic [7:0]       r_op_b;
    logic [2:0]       r_op_sel;
    logic             r_op_id;
    logic             r_rsp_id;
    logic [7:0]       r_rsp_result;
    logic             r_rsp_carry;
    logic [CNT_W-1:0] r_op_count;

    logic w_grant0;
    logic w_grant1;
    logic w_take0;
    logic w_take1;

    // On a tie the requester that did not win last time gets the ALU
    assign w_grant0   = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
    assign req0_ready = (r_state == ST_IDLE) & w_grant0 & ~rst;
    assign req1_ready = (r_state == ST_IDLE) & w_grant1 & ~rst;
    assign w_take0    = req0_valid & req0_ready;
    assign w_take1    = req1_valid & req1_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_take0 | w_take1) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_acc0       <= 8'h00;
            r_acc1       <= 8'h00;
            r_op_a       <= 8'h00;
            r_op_b       <= 8'h00;
            r_op_sel     <= 3'd0;
            r_op_id      <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_carry  <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take0) begin
                r_op_a   <= req0_use_acc ? r_acc0 : req0_a;
                r_op_b   <= req0_b;
                r_op_sel <= req0_sel;
                r_op_id  <= 1'b0;
            end else if (w_take1) begin
                r_op_a   <= req1_use_acc ? r_acc1 : req1_a;
                r_op_b   <= req1_b;
                r_op_sel <= req1_sel;
                r_op_id  <= 1'b1;
            end
            // Accumulator commits here regardless of later response back-pressure
            if (r_state == ST_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_carry  <= alu_carry;
                r_rsp_id     <= r_op_id;
                r_last_grant <= r_op_id;
                r_op_count   <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_op_id) r_acc1 <= alu_result;
                else         r_acc0 <= alu_result;
            end
        end
    end

    assign alu_a      = r_op_a;
    assign alu_b      = r_op_b;
    assign alu_sel    = r_op_sel;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_scheduler
// Purpose  : Directed scoreboard bench for alu_op_scheduler with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_op_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_use_acc = 1'b0;
    logic [7:0]  req0_a = 8'h00, req0_b = 8'h00;
    logic [2:0]  req0_sel = 3'd0;
    logic        req1_valid = 1'b0, req1_use_acc = 1'b0;
    logic [7:0]  req1_a = 8'h00, req1_b = 8'h00;
    logic [2:0]  req1_sel = 3'd0;
    logic        rsp_ready = 1'b1;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry;
    logic [7:0]  rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        alu_carry;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        id;
        logic [7:0]  res;
        logic        carry;
        logic [15:0] cnt;
    } exp_t;
    exp_t q[$];

    alu_op_scheduler #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sel(req0_sel), .req0_use_acc(req0_use_acc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sel(req1_sel), .req1_use_acc(req1_use_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; shifts use b[2:0] as the shift amount
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_sel)
            3'b000, 3'b111: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: begin alu_result = alu_a - alu_b; alu_carry = (alu_a >= alu_b); end
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = alu_a << alu_b[2:0];
            default: alu_result = alu_a >> alu_b[2:0];
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got id %0d result 0x%0h expected none", rsp_id, rsp_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                check("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
                check("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
                check("op_count", {16'd0, op_count}, {16'd0, e.cnt});
            end
        end
    end

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sel, input logic ua);
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_sel = sel; req0_use_acc = ua; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sel = sel; req1_use_acc = ua; req1_valid = 1'b1;
        end
    endtask

    // Drive one request until accepted, then drop valid just after the accepting edge
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel, input logic ua,
                         input logic [7:0] er, input logic ec, input logic [15:0] ecnt);
        bit got = 0;
        q.push_back({id[0], er, ec, ecnt});
        set_req(id, a, b, sel, ua);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        // Reset state, with requests pending to show ready is held low
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_alu", {13'd0, alu_a, alu_b, alu_sel}, 32'd0);
        check("rst_rsp", {22'd0, rsp_id, rsp_result, rsp_carry}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single add with explicit latency check
        do_op(0, 8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 16'd1);
        @(negedge clk);
        check("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("exec_alu_a", {24'd0, alu_a}, 32'hFF);
        @(negedge clk);
        check("lat_resp_valid", {31'd0, rsp_valid}, 32'd1);
        drain();

        // Subtraction with and without borrow
        do_op(1, 8'h10, 8'h01, 3'b001, 1'b0, 8'h0F, 1'b1, 16'd2);
        drain();
        do_op(1, 8'h01, 8'h02, 3'b001, 1'b0, 8'hFF, 1'b0, 16'd3);
        drain();

        // Fairness: both valid continuously, grants alternate from requester 0
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) q.push_back({1'b0, 8'h02, 1'b0, 16'(4 + i)});
            else            q.push_back({1'b1, 8'h01, 1'b1, 16'(4 + i)});
        end
        set_req(0, 8'h01, 8'h01, 3'b000, 1'b0);
        set_req(1, 8'h03, 8'h02, 3'b001, 1'b0);
        drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an operation
        set_req(0, 8'h11, 8'h22, 3'b000, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        set_req(1, 8'h01, 8'h01, 3'b000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Tie after reset goes to requester 0; both accumulators read back as zero
        q.push_back({1'b0, 8'h00, 1'b0, 16'd1});
        q.push_back({1'b1, 8'h00, 1'b0, 16'd2});
        set_req(0, 8'hAA, 8'h00, 3'b011, 1'b1);
        set_req(1, 8'h55, 8'h00, 3'b011, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) break;
        end
        check("tie_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        drain();
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Accumulator chaining on requester 0
        do_op(0, 8'h05, 8'h03, 3'b000, 1'b0, 8'h08, 1'b0, 16'd3);
        drain();
        do_op(0, 8'hEE, 8'h0F, 3'b010, 1'b1, 8'h08, 1'b0, 16'd4);
        drain();
        do_op(0, 8'hEE, 8'h01, 3'b101, 1'b1, 8'h10, 1'b0, 16'd5);
        drain();
        do_op(1, 8'h77, 8'h00, 3'b011, 1'b1, 8'h00, 1'b0, 16'd6);
        drain();

        // Back-pressure: response held for 5 cycles, requester 1 kept waiting
        rsp_ready = 1'b0;
        do_op(0, 8'h20, 8'h22, 3'b100, 1'b0, 8'h02, 1'b0, 16'd7);
        set_req(1, 8'h07, 8'h01, 3'b110, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_result", {23'd0, rsp_id, rsp_result}, 32'h002);
            check("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        q.push_back({1'b1, 8'h03, 1'b0, 16'd8});
        @(posedge clk);
        @(negedge clk);
        check("bp_next_accept", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
